// File: rtl/tube_bus_pkg.sv
// Shared types and constants for the Tube bus controller.
// The optional interrupt forwarding path is enabled by defining TUBE_IRQ_FWD_EN.
package tube_bus_pkg;

    // Bus sequencer states, in the order a Tube cycle walks through them.
    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } tube_state_e;

    // Host address bit that selects the local register instead of the Tube.
    localparam int LOCAL_SEL = 3;

    // Local register write bits.
    localparam int CTRL_SOFT_RST = 0;
    localparam int CTRL_IRQ_MASK = 1;

    // Local register read bits.
    localparam int STAT_IN_RST   = 0;
    localparam int STAT_IRQ_MASK = 1;
    localparam int STAT_TUBE_INT = 7;

    // True in the states where chip select is asserted on the Tube bus.
    function automatic logic on_bus(input tube_state_e s);
        return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/tube_phase_cnt.sv
// Loadable down-counter that times both the Tube reset pulse and the
// phi2 high phase. It stops at zero and reports when it gets there.
module tube_phase_cnt #(
    parameter int unsigned    W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins over a decrement; never wrap below zero.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register; powers up holding the reset pulse length.
    always_ff @(posedge clk or negedge reset_b) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_b) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tube_bus_ctrl.sv
// Tube bus controller: turns 6809 host accesses in the BASE_NIB 4 KB window
// into Tube ULA bus cycles, owns the Tube reset pulse and provides a small
// control/status register. Define TUBE_IRQ_FWD_EN to forward the Tube
// interrupt to the host through a synchronizer and the mask bit.
module tube_bus_ctrl
    import tube_bus_pkg::*;
#(
    parameter logic [3:0]  BASE_NIB   = 4'hB,
    parameter int unsigned PHI2_HIGH  = 4,
    parameter int unsigned RST_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] host_adr,
    input  logic        host_valid,
    input  logic        host_rnw,
    input  logic [7:0]  host_din,
    output logic [7:0]  host_dout,
    output logic        host_dout_oe,
    output logic        host_rdy,
    output logic        host_irq_b,
    input  logic        tube_int_b,
    input  logic [7:0]  tube_din,
    output logic [7:0]  tube_dout,
    output logic        tube_dout_oe,
    output logic [2:0]  tube_adr,
    output logic        tube_rnw_b,
    output logic        tube_phi2,
    output logic        tube_cs_b,
    output logic        tube_rst_b
);

    // Counter reload values: the counter reaches zero on the last cycle of a phase.
    localparam logic [7:0] RST_LOAD  = 8'(RST_CYCLES - 1);
    localparam logic [7:0] PHI2_LOAD = 8'(PHI2_HIGH - 1);

    // Address decode.
    logic hit;
    logic local_hit;
    logic tube_hit;
    logic local_wr;
    logic soft_rst;

    assign hit       = host_valid && (host_adr[15:12] == BASE_NIB);
    assign local_hit = hit && host_adr[LOCAL_SEL];
    assign tube_hit  = hit && !host_adr[LOCAL_SEL];

    // Sequencer state and registered bus outputs.
    tube_state_e state_q, state_d;
    logic        tube_rst_b_q,   tube_rst_b_d;
    logic        tube_cs_b_q,    tube_cs_b_d;
    logic        tube_phi2_q,    tube_phi2_d;
    logic        tube_rnw_b_q,   tube_rnw_b_d;
    logic [2:0]  tube_adr_q,     tube_adr_d;
    logic [7:0]  tube_dout_q,    tube_dout_d;
    logic        tube_dout_oe_q, tube_dout_oe_d;
    logic [7:0]  rd_data_q,      rd_data_d;
    logic        irq_mask_q,     irq_mask_d;

    // Shared phase counter controls.
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       cnt_dec;
    logic       cnt_zero;

    // Local writes land whenever the host is not being held off by reset;
    // soft reset only takes effect from IDLE so a Tube cycle is never cut short.
    assign local_wr = local_hit && !host_rnw && (state_q != ST_RST);
    assign soft_rst = local_wr && host_din[CTRL_SOFT_RST] && (state_q == ST_IDLE);

    tube_phase_cnt #(
        .W         (8),
        .RESET_VAL (RST_LOAD)
    ) u_phase_cnt (
        .clk      (clk),
        .reset_b  (reset_b),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next state, counter control and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        tube_adr_d   = tube_adr_q;
        tube_rnw_b_d = tube_rnw_b_q;
        tube_dout_d  = tube_dout_q;
        irq_mask_d   = local_wr ? host_din[CTRL_IRQ_MASK] : irq_mask_q;
        rd_data_d    = rd_data_q;

        unique case (state_q)
            ST_RST: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_IDLE: begin
                if (soft_rst) begin
                    state_d      = ST_RST;
                    cnt_load     = 1'b1;
                    cnt_load_val = RST_LOAD;
                end else if (tube_hit) begin
                    state_d      = ST_SETUP;
                    tube_adr_d   = host_adr[2:0];
                    tube_rnw_b_d = host_rnw;
                    tube_dout_d  = host_din;
                end
            end
            ST_SETUP: begin
                state_d      = ST_STROBE;
                cnt_load     = 1'b1;
                cnt_load_val = PHI2_LOAD;
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    if (tube_rnw_b_q) begin
                        rd_data_d = tube_din;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!host_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        // Bus strobes are registered from the state being entered so they
        // change cleanly on the same edge as the state.
        tube_rst_b_d   = (state_d != ST_RST);
        tube_cs_b_d    = !on_bus(state_d);
        tube_phi2_d    = (state_d == ST_STROBE);
        tube_dout_oe_d = on_bus(state_d) && !tube_rnw_b_d;
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q        <= ST_RST;
            tube_rst_b_q   <= 1'b0;
            tube_cs_b_q    <= 1'b1;
            tube_phi2_q    <= 1'b0;
            tube_rnw_b_q   <= 1'b1;
            tube_adr_q     <= '0;
            tube_dout_q    <= '0;
            tube_dout_oe_q <= 1'b0;
            rd_data_q      <= '0;
            irq_mask_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            tube_rst_b_q   <= tube_rst_b_d;
            tube_cs_b_q    <= tube_cs_b_d;
            tube_phi2_q    <= tube_phi2_d;
            tube_rnw_b_q   <= tube_rnw_b_d;
            tube_adr_q     <= tube_adr_d;
            tube_dout_q    <= tube_dout_d;
            tube_dout_oe_q <= tube_dout_oe_d;
            rd_data_q      <= rd_data_d;
            irq_mask_q     <= irq_mask_d;
        end
    end

    // Interrupt forwarding.
    logic int_active;

`ifdef TUBE_IRQ_FWD_EN
    logic [1:0] int_sync_q;
    logic [1:0] int_sync_d;

    assign int_sync_d = {int_sync_q[0], tube_int_b};

    // Two-flop synchronizer for the asynchronous Tube interrupt, idling high.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            int_sync_q <= 2'b11;
        end else begin
            int_sync_q <= int_sync_d;
        end
    end

    assign int_active = !int_sync_q[1];
    assign host_irq_b = !(int_active && irq_mask_q);

    logic unused_inputs;
    assign unused_inputs = ^host_adr[11:4];
`else
    assign int_active = 1'b0;
    assign host_irq_b = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{host_adr[11:4], tube_int_b};
`endif

    // Host side: the host waits for any Tube cycle to finish, and for any hit at all during reset.
    logic [7:0] status;

    // Status byte seen on local register reads.
    always_comb begin
        status                = '0;
        status[STAT_IN_RST]   = (state_q == ST_RST);
        status[STAT_IRQ_MASK] = irq_mask_q;
        status[STAT_TUBE_INT] = int_active;
    end

    assign host_rdy     = !((tube_hit && (state_q != ST_DONE)) || (hit && (state_q == ST_RST)));
    assign host_dout_oe = hit && host_rnw && ((state_q == ST_DONE) || local_hit);
    assign host_dout    = !host_dout_oe ? 8'h00 : (local_hit ? status : rd_data_q);

    assign tube_rst_b   = tube_rst_b_q;
    assign tube_cs_b    = tube_cs_b_q;
    assign tube_phi2    = tube_phi2_q;
    assign tube_rnw_b   = tube_rnw_b_q;
    assign tube_adr     = tube_adr_q;
    assign tube_dout    = tube_dout_q;
    assign tube_dout_oe = tube_dout_oe_q;

endmodule

// File: tb/tb_tube_bus_ctrl.sv
// Self-checking bench for tube_bus_ctrl with default parameters.
// A cycle-count model tracks reset time and the phase of any Tube access
// and is compared with the DUT on every falling edge; directed scenarios
// add literal expectations. TUBE_IRQ_FWD_EN enables the interrupt scenario.
module tb_tube_bus_ctrl;

    localparam int P    = 4;   // phi2 high cycles
    localparam int RSTC = 64;  // reset pulse cycles

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [15:0] host_adr = '0;
    logic        host_valid = 1'b0;
    logic        host_rnw = 1'b1;
    logic [7:0]  host_din = '0;
    logic [7:0]  host_dout;
    logic        host_dout_oe;
    logic        host_rdy;
    logic        host_irq_b;
    logic        tube_int_b = 1'b1;
    logic [7:0]  tube_din = '0;
    logic [7:0]  tube_dout;
    logic        tube_dout_oe;
    logic [2:0]  tube_adr;
    logic        tube_rnw_b;
    logic        tube_phi2;
    logic        tube_cs_b;
    logic        tube_rst_b;

    int total = 0;
    int bad   = 0;

    tube_bus_ctrl dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .host_adr     (host_adr),
        .host_valid   (host_valid),
        .host_rnw     (host_rnw),
        .host_din     (host_din),
        .host_dout    (host_dout),
        .host_dout_oe (host_dout_oe),
        .host_rdy     (host_rdy),
        .host_irq_b   (host_irq_b),
        .tube_int_b   (tube_int_b),
        .tube_din     (tube_din),
        .tube_dout    (tube_dout),
        .tube_dout_oe (tube_dout_oe),
        .tube_adr     (tube_adr),
        .tube_rnw_b   (tube_rnw_b),
        .tube_phi2    (tube_phi2),
        .tube_cs_b    (tube_cs_b),
        .tube_rst_b   (tube_rst_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Strobe counters, cleared by the stimulus before each scenario.
    int phi2_cnt = 0, cs_cnt = 0, oe_cnt = 0, rstlow_cnt = 0;

    always @(negedge clk) begin
        if (reset_b) begin
            phi2_cnt   += int'(tube_phi2);
            cs_cnt     += int'(!tube_cs_b);
            oe_cnt     += int'(tube_dout_oe);
            rstlow_cnt += int'(!tube_rst_b);
        end
    end

    task automatic clr_counts();
        phi2_cnt = 0; cs_cnt = 0; oe_cnt = 0; rstlow_cnt = 0;
    endtask

    // Model: reset time remaining, and phase k of the current Tube access
    // (0 = none, 1 = setup, 2..P+1 = phi2 high, P+2 = hold, >= P+3 = done).
    bit         m_live = 0;
    bit         m_in_rst;
    int         m_rst_left;
    int         m_k;
    bit         m_mask;
    logic       m_rnw;
    logic [2:0] m_adr;
    logic [7:0] m_wd;
    logic [7:0] m_rd;

    always @(negedge clk) begin
        if (!reset_b) begin
            m_live = 1; m_in_rst = 1; m_rst_left = RSTC; m_k = 0; m_mask = 0;
            m_rnw = 1; m_adr = '0; m_wd = '0; m_rd = '0;
        end else if (m_live) begin
            automatic bit hit    = host_valid && (host_adr[15:12] == 4'hB);
            automatic bit loc    = hit && host_adr[3];
            automatic bit th     = hit && !host_adr[3];
            automatic bit done   = (m_k >= P + 3);
            automatic bit on_bus = (m_k >= 1) && (m_k <= P + 2);
            automatic bit e_oe   = hit && host_rnw && (done || loc);
            check("m_rst_b",   tube_rst_b,   !m_in_rst);
            check("m_cs_b",    tube_cs_b,    !on_bus);
            check("m_phi2",    tube_phi2,    (m_k >= 2) && (m_k <= P + 1));
            check("m_tdoe",    tube_dout_oe, on_bus && !m_rnw);
            check("m_rnw_b",   tube_rnw_b,   m_rnw);
            check("m_tadr",    tube_adr,     m_adr);
            check("m_tdout",   tube_dout,    m_wd);
            check("m_rdy",     host_rdy,     !((th && !done) || (hit && m_in_rst)));
            check("m_hdoe",    host_dout_oe, e_oe);
            if (e_oe)
                check("m_hdout", host_dout, loc ? {6'b0, m_mask, m_in_rst} : m_rd);
`ifndef TUBE_IRQ_FWD_EN
            check("m_irq_b",   host_irq_b,   1'b1);
`endif
            // Advance to the next cycle from the inputs the DUT samples at the coming edge.
            if (loc && !host_rnw && !m_in_rst) m_mask = host_din[1];
            if (m_in_rst) begin
                m_rst_left--;
                if (m_rst_left == 0) m_in_rst = 0;
            end else if (m_k == 0) begin
                if (loc && !host_rnw && host_din[0]) begin
                    m_in_rst = 1; m_rst_left = RSTC;
                end else if (th) begin
                    m_k = 1; m_rnw = host_rnw; m_adr = host_adr[2:0]; m_wd = host_din;
                end
            end else if (!done) begin
                if (m_k == P + 1 && m_rnw) m_rd = tube_din;
                m_k++;
            end else if (!host_valid) begin
                m_k = 0;
            end
        end
    end

    // One host access: hold valid until host_rdy, capture data, then release.
    task automatic host_xfer(input logic [15:0] adr, input logic rnw, input logic [7:0] din,
                             output int lat, output logic [7:0] rdata);
        bit got;
        @(posedge clk); #1;
        host_adr = adr; host_rnw = rnw; host_din = din; host_valid = 1'b1;
        lat = 0; got = 0; rdata = '0;
        while (!got && lat < 300) begin
            @(negedge clk);
            if (host_rdy) begin
                got = 1; rdata = host_dout;
            end else begin
                lat++;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL rdy_timeout: got no host_rdy, want it within 300 cycles");
        end
        @(posedge clk); #1;
        host_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want it before 200000 ns");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [7:0] rd;

        // Reset values.
        tube_din = 8'h3C;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tube_rst_b", tube_rst_b, 1'b0);
        check("rst_cs_b",       tube_cs_b,  1'b1);
        check("rst_phi2",       tube_phi2,  1'b0);
        check("rst_rnw_b",      tube_rnw_b, 1'b1);
        check("rst_adr",        tube_adr,   3'd0);
        check("rst_tdout",      {tube_dout, tube_dout_oe, host_dout_oe}, 10'd0);
        check("rst_irq_b",      host_irq_b, 1'b1);

        // Release; a Tube read at 0xB001 is held off through the 64-cycle reset and then serviced.
        clr_counts();
        @(posedge clk); #1;
        reset_b = 1'b1;
        host_xfer(16'hB001, 1'b1, 8'h00, lat, rd);
        check("rst_low_cycles", rstlow_cnt, 64);
        check("rst_hit_lat",    lat,        70);
        check("rst_hit_data",   rd,         8'h3C);

        // Tube read at 0xB003.
        tube_din = 8'h5A;
        clr_counts();
        host_xfer(16'hB003, 1'b1, 8'h00, lat, rd);
        check("rd_lat",   lat,      7);
        check("rd_data",  rd,       8'h5A);
        check("rd_phi2",  phi2_cnt, 4);
        check("rd_cs",    cs_cnt,   6);
        check("rd_oe",    oe_cnt,   0);
        check("rd_adr",   tube_adr, 3'd3);
        check("rd_rnw_b", tube_rnw_b, 1'b1);

        // Tube write of 0xA5 to 0xB006.
        tube_din = 8'h00;
        clr_counts();
        host_xfer(16'hB006, 1'b0, 8'hA5, lat, rd);
        check("wr_lat",   lat,        7);
        check("wr_cs",    cs_cnt,     6);
        check("wr_oe",    oe_cnt,     6);
        check("wr_phi2",  phi2_cnt,   4);
        check("wr_dout",  tube_dout,  8'hA5);
        check("wr_rnw_b", tube_rnw_b, 1'b0);
        check("wr_adr",   tube_adr,   3'd6);

        // Local register: zero wait states, mask bit read back.
        host_xfer(16'hB008, 1'b1, 8'h00, lat, rd);
        check("loc_rd0_lat",  lat, 0);
        check("loc_rd0_data", rd,  8'h00);
        host_xfer(16'hB008, 1'b0, 8'h02, lat, rd);
        check("loc_wr_lat",   lat, 0);
        host_xfer(16'hB008, 1'b1, 8'h00, lat, rd);
        check("loc_rd1_data", rd,  8'h02);

        // Soft reset; status shows bit0 while the Tube reset pulse runs.
        clr_counts();
        host_xfer(16'hB008, 1'b0, 8'h01, lat, rd);
        repeat (4) @(posedge clk);
        #1;
        host_adr = 16'hB008; host_rnw = 1'b1; host_valid = 1'b1;
        @(negedge clk);
        check("srst_rdy",   host_rdy,  1'b0);
        check("srst_stat",  host_dout, 8'h01);
        @(posedge clk); #1;
        host_valid = 1'b0;
        repeat (70) @(posedge clk);
        check("srst_low_cycles", rstlow_cnt, 64);
        host_xfer(16'hB008, 1'b1, 8'h00, lat, rd);
        check("srst_after", rd, 8'h00);

        // host_valid dropped in the second phi2 cycle: strobe still completes, no repeat.
        clr_counts();
        @(posedge clk); #1;
        host_adr = 16'hB002; host_rnw = 1'b1; host_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        host_valid = 1'b0;
        repeat (12) @(posedge clk);
        check("drop_phi2", phi2_cnt, 4);
        check("drop_cs",   cs_cnt,   6);
        clr_counts();
        host_xfer(16'hB004, 1'b1, 8'h00, lat, rd);
        check("drop_next_lat", lat, 7);

        // Soft-reset write while still in DONE (valid held, address moved) is ignored.
        clr_counts();
        @(posedge clk); #1;
        host_adr = 16'hB001; host_rnw = 1'b1; host_valid = 1'b1;
        lat = 0;
        while (!host_rdy && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk); #1;
        host_adr = 16'hB008; host_rnw = 1'b0; host_din = 8'h01;
        @(posedge clk); #1;
        host_valid = 1'b0;
        repeat (6) @(posedge clk);
        check("busy_srst_ignored", rstlow_cnt, 0);
        check("busy_cs",           cs_cnt,     6);

`ifdef TUBE_IRQ_FWD_EN
        // Interrupt forwarding through the synchronizer and mask.
        host_xfer(16'hB008, 1'b0, 8'h02, lat, rd);
        @(posedge clk); #1;
        tube_int_b = 1'b0;
        lat = 0;
        while (host_irq_b && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("irq_lat_le3", lat <= 3, 1'b1);
        host_xfer(16'hB008, 1'b0, 8'h00, lat, rd);
        #1;
        check("irq_masked", host_irq_b, 1'b1);
        tube_int_b = 1'b1;
        repeat (4) @(posedge clk);
`endif

        // Asynchronous reset mid-write drops every Tube output at once.
        @(posedge clk); #1;
        host_adr = 16'hB005; host_rnw = 1'b0; host_din = 8'h77; host_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("amid_cs_before", tube_cs_b, 1'b0);
        reset_b = 1'b0;
        #1;
        check("amid_cs_b",  tube_cs_b,    1'b1);
        check("amid_phi2",  tube_phi2,    1'b0);
        check("amid_oe",    tube_dout_oe, 1'b0);
        check("amid_rst_b", tube_rst_b,   1'b0);
        check("amid_dout",  {tube_dout, tube_adr, tube_rnw_b}, {8'h00, 3'd0, 1'b1});
        host_valid = 1'b0;
        clr_counts();
        @(posedge clk); #1;
        reset_b = 1'b1;
        repeat (70) @(posedge clk);
        check("amid_rst_cycles", rstlow_cnt, 64);
        clr_counts();
        host_xfer(16'hB007, 1'b0, 8'h3E, lat, rd);
        check("amid_after_lat", lat,       7);
        check("amid_after_dat", tube_dout, 8'h3E);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tube_bus_ctrl.md
Name: tube_bus_ctrl

Overview:
Sequences 6809 host accesses onto the Tube ULA parasite bus and generates tube_cs_b, tube_rnw_b, tube_adr and a stretched tube_phi2 strobe from the fast system clock. While a Tube cycle is in flight, host_rdy holds the host off. The block also owns the Tube reset pulse, after power-on or soft reset, and exposes a small local control/status register. It sits on the bus card beside the UART, decoding its own 4 KB host window.

Parameters:
BASE_NIB, 4'hB, adr[15:12] value that selects this block (0xBxxx).
PHI2_HIGH, 4, tube_phi2 high time in clk cycles; legal range 1..15.
RST_CYCLES, 64, tube_rst_b low time in clk cycles; legal range 2..255.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset_b  in  1  reset, asynchronous, active-low.
host_adr  in  16  host address.
host_valid  in  1  host address/control valid, synchronous to clk.
host_rnw  in  1  1 = read, 0 = write.
host_din  in  8  host write data.
host_dout  out  8  read data to host.
host_dout_oe  out  1  host data bus drive enable.
host_rdy  out  1  0 = stretch the host cycle.
host_irq_b  out  1  interrupt to host, active-low.
tube_int_b  in  1  Tube interrupt, asynchronous.
tube_din  in  8  Tube data bus in.
tube_dout  out  8  Tube data bus out.
tube_dout_oe  out  1  Tube data bus drive enable.
tube_adr  out  3  Tube register select.
tube_rnw_b  out  1  Tube read/not-write.
tube_phi2  out  1  Tube clock strobe.
tube_cs_b  out  1  Tube chip select, active-low.
tube_rst_b  out  1  Tube reset, active-low.

Behaviour:
- Decode: hit = host_valid & host_adr[15:12]==BASE_NIB. Tube access when hit & adr[3]==0 (tube_adr = adr[2:0]). Local register access when hit & adr[3]==1.
- FSM states and transitions:
  - RST: tube_rst_b=0; counter runs RST_CYCLES, then IDLE.
  - IDLE: Tube hit → SETUP; tube_adr, tube_rnw_b and tube_dout are registered from the host.
  - SETUP: 1 cycle; tube_cs_b=0, phi2=0; then STROBE.
  - STROBE: PHI2_HIGH cycles with phi2=1, cs_b=0. On a read, tube_din is latched into a read register on the final STROBE cycle.
  - HOLD: 1 cycle; phi2=0, cs_b=0, write data still driven; then DONE.
  - DONE: cs_b=1. Leaves to IDLE when host_valid=0.
- Reset values: state RST, tube_rst_b=0, tube_cs_b=1, tube_phi2=0, tube_rnw_b=1, tube_adr=0, tube_dout=0, tube_dout_oe=0, host_dout=0, host_dout_oe=0, host_irq_b=1, control reg=0.
- host_rdy is combinational: 0 when a Tube hit is present and state!=DONE, or when any hit is present during RST; otherwise 1.
- Latency: host_valid asserted in cycle 0 (state IDLE) → host_rdy=1 in cycle PHI2_HIGH+3.
- tube_dout_oe = write & state in {SETUP, STROBE, HOLD}.
- host_dout_oe = hit & host_rnw & (state==DONE | local access).
- Local register (adr[3]=1) responds in 0 wait cycles.
  - Write: bit0 soft reset, self-clearing, enters RST at the next edge. bit1 irq_mask.
  - Read: bit7 = synced Tube interrupt state (1 = asserted), bit1 = mask, bit0 = 1 while in RST, other bits 0.
- A Tube cycle, once started, always runs to DONE. host_valid dropping mid-cycle does not truncate tube_phi2. DONE then exits to IDLE the next cycle.
- A soft-reset write while the FSM is not IDLE is ignored.
- A Tube hit during RST is stretched and serviced after RST → IDLE.
- Asynchronous reset mid-cycle forces all Tube outputs to their reset values immediately.

Optional Feature:
TUBE_IRQ_FWD_EN:
- Defined: tube_int_b passes through a 2-flop synchronizer (reset value 1). host_irq_b = !(int_sync & irq_mask); IRQ latency is 2–3 clk.
- Undefined: host_irq_b is tied 1, status bit7 reads 0, bit1 is writable but has no effect.

Decomposition:
- Package tube_bus_pkg: FSM state enum (RST, IDLE, SETUP, STROBE, HOLD, DONE), local register bit indices, LOCAL_SEL bit (3).
- One natural sub-module: tube_phase_cnt, a loadable down-counter shared by the RST and STROBE timing.

Test Plan:
- Release reset_b → tube_rst_b low exactly 64 clk, then 1; a host hit at 0xB001 during that window keeps host_rdy=0 until after release.
- Read 0xB003 with tube_din=0x5A → tube_adr=3, tube_rnw_b=1, phi2 high 4 clk, host_rdy high at cycle 7, host_dout=0x5A.
- Write 0x A5 to 0xB006 → tube_rnw_b=0, tube_dout=0xA5 with oe=1 from SETUP through HOLD, cs_b low 6 clk.
- Write 0x01 to 0xB008 → tube_rst_b low 64 clk; reading 0xB008 during that window returns bit0=1.
- Drop host_valid in the 2nd STROBE cycle → phi2 still high 4 clk, FSM returns to IDLE, no second access.
- With TUBE_IRQ_FWD_EN, write 0x02 to 0xB008, then drive tube_int_b=0 → host_irq_b=0 within 3 clk; clearing the mask → host_irq_b=1.
